vdcmul_16b_seq: RTL and testbench



---
 rtl/vdcmul_16b_seq.sv | 200 ++++++++++++++++++++
 tb/tb_vdcmul_16b_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdcmul_16b_seq.sv
// vdcmul_16b_seq: sequential 16x16 unsigned multiplier built around one
// combinational 8x8 Vedic multiplier. The four 8-bit partial products are
// formed one per cycle and accumulated into a 32-bit result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b presented
//   in_ready   operands accepted this cycle (IDLE and not in reset)
//   a, b       16-bit unsigned operands
//   out_valid  prod holds a completed result (registered)
//   out_ready  consumer takes the result this cycle
//   prod       registered 32-bit product
//   busy       high in any state other than IDLE

// 2x2 Vedic multiplier: vertical and crosswise terms.
module vdcmul_2b (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_carry;

    always_comb begin
        cross_carry = (a[1] & b[0]) & (a[0] & b[1]);
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        p[2] = cross_carry ^ (a[1] & b[1]);
        p[3] = cross_carry & (a[1] & b[1]);
    end
endmodule

// 4x4 Vedic multiplier composed of four 2x2 blocks.
module vdcmul_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] mid;

    vdcmul_2b u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vdcmul_2b u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vdcmul_2b u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vdcmul_2b u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // Crosswise terms share the same weight and are summed before shifting.
    always_comb begin
        mid = 6'(q1) + 6'(q2);
        p   = 8'(q0) + (8'(mid) << 2) + (8'(q3) << 4);
    end
endmodule

// 8x8 Vedic multiplier composed of four 4x4 blocks.
module vdcmul_8b (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] q0, q1, q2, q3;
    logic [9:0] mid;

    vdcmul_4b u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
    vdcmul_4b u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
    vdcmul_4b u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
    vdcmul_4b u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

    always_comb begin
        mid = 10'(q1) + 10'(q2);
        p   = 16'(q0) + (16'(mid) << 4) + (16'(q3) << 8);
    end
endmodule

module vdcmul_16b_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] prod,
    output logic        busy
);
    localparam int unsigned OP_W   = 16;
    localparam int unsigned HALF_W = 8;
    localparam int unsigned PP_W   = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned K_W    = 2;
    localparam int unsigned SH_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [OP_W-1:0]   a_q, b_q;
    logic [K_W-1:0]    k;
    logic [ACC_W-1:0]  acc;
    logic [HALF_W-1:0] mul_a, mul_b;
    logic [PP_W-1:0]   pp;
    logic [SH_W-1:0]   shift;
    logic [ACC_W-1:0]  acc_sum;

    logic load_ops;
    logic do_step;
    logic do_finish;
    logic do_handshake;

    // Status decode: state register only, gated by reset for in_ready.
    assign in_ready = (state == ST_IDLE) && !rst;
    assign busy     = (state != ST_IDLE);

    // Operand mux: k[1] picks the a half, k[0] picks the b half.
    always_comb begin
        mul_a = k[1] ? a_q[15:8] : a_q[7:0];
        mul_b = k[0] ? b_q[15:8] : b_q[7:0];
        unique case (k)
            2'd0:    shift = SH_W'(0);
            2'd3:    shift = SH_W'(16);
            default: shift = SH_W'(8);
        endcase
    end

    vdcmul_8b u_mul (.a(mul_a), .b(mul_b), .p(pp));

    assign acc_sum = acc + (ACC_W'(pp) << shift);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt    = state;
        load_ops     = 1'b0;
        do_step      = 1'b0;
        do_finish    = 1'b0;
        do_handshake = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load_ops  = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                do_step = 1'b1;
                if (k == K_W'(3)) begin
                    do_finish = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    do_handshake = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            acc       <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load_ops) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                k   <= '0;
            end else if (do_step) begin
                acc <= acc_sum;
                k   <= k + K_W'(1);
            end
            if (do_finish) begin
                prod      <= acc_sum;
                out_valid <= 1'b1;
            end else if (do_handshake) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vdcmul_16b_seq.sv
// Self-checking bench for vdcmul_16b_seq. Expected products come from plain
// 32-bit arithmetic on the operands the bench presented at acceptance.
module tb_vdcmul_16b_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    vdcmul_16b_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents x/y until accepted; after return operands get scrambled.
    task automatic present(input logic [15:0] x, input logic [15:0] y, output bit ok);
        logic r;
        ok = 1'b0;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = in_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Counts edges until out_valid, scrambling operands every cycle.
    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            a = 16'($urandom);
            b = 16'($urandom);
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        a = 16'h1111;
        b = 16'h2222;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_status got out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        checks++;
        if (prod !== 32'h0) begin errors++; $display("FAIL reset_prod got %h want 00000000", prod); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        out_ready = 1'b1;
        present(16'h1234, 16'h5678, ok);
        wait_out(lat, ok);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++;
        if (prod !== 32'h06260060) begin errors++; $display("FAIL basic_prod got %h want 06260060", prod); end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_done_status got busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_after_hs got ov=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (prod !== 32'h06260060) begin errors++; $display("FAIL basic_prod_hold got %h want 06260060", prod); end
    endtask

    task automatic test_carry();
        logic [15:0] xs[7];
        logic [15:0] ys[7];
        bit ok;
        int lat;
        xs[0] = 16'hFFFF; ys[0] = 16'hFFFF;
        xs[1] = 16'h00FF; ys[1] = 16'h0100;
        xs[2] = 16'h0000; ys[2] = 16'hABCD;
        xs[3] = 16'hFF00; ys[3] = 16'h00FF;
        for (int i = 4; i < 7; i++) begin
            xs[i] = 16'($urandom);
            ys[i] = 16'($urandom);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            present(xs[i], ys[i], ok);
            wait_out(lat, ok);
            checks++;
            if (!ok || prod !== model(xs[i], ys[i])) begin
                errors++;
                $display("FAIL carry_%0d got %h want %h", i, prod, model(xs[i], ys[i]));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] x, y, x2, y2;
        bit ok;
        int lat;
        int bad;
        x = 16'($urandom);
        y = 16'($urandom);
        out_ready = 1'b0;
        present(x, y, ok);
        wait_out(lat, ok);
        x2 = 16'($urandom);
        y2 = 16'($urandom);
        a = x2;
        b = y2;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || prod !== model(x, y) || in_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++; $display("FAIL backpressure_hold got %0d bad cycles want 0", bad);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_hs got ov=%b busy=%b want 0 0", out_valid, busy);
        end
        present(x2, y2, ok);
        wait_out(lat, ok);
        checks++;
        if (!ok || prod !== model(x2, y2)) begin
            errors++; $display("FAIL backpressure_next got %h want %h", prod, model(x2, y2));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int lat;
        logic [31:0] old_prod;
        out_ready = 1'b1;
        old_prod = prod;
        present(16'($urandom | 1), 16'($urandom | 1), ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (prod !== 32'h0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state got prod=%h busy=%b ov=%b want 0 0 0 (prev %h)", prod, busy, out_valid, old_prod);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_discard got out_valid=1 want 0"); end
        present(16'd3, 16'd5, ok);
        wait_out(lat, ok);
        checks++;
        if (!ok || prod !== 32'd15) begin errors++; $display("FAIL reset_mid_next got %h want 0000000f", prod); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[8];
        logic [15:0] pb[8];
        logic [31:0] q[$];
        int acc_t[8];
        int idx, got, bad, iv;
        logic r, v;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
        end
        idx = 0;
        got = 0;
        bad = 0;
        out_ready = 1'b1;
        a = pa[0];
        b = pb[0];
        in_valid = 1'b1;
        for (int c = 0; c < 200 && got < 8; c++) begin
            r = in_ready & in_valid;
            v = out_valid;
            if (v) begin
                if (q.size() == 0) begin
                    bad++;
                end else begin
                    e = q.pop_front();
                    if (prod !== e) bad++;
                end
                got++;
            end
            if (r) begin
                q.push_back(model(pa[idx], pb[idx]));
                acc_t[idx] = cycle;
                idx++;
            end
            tick();
            if (r) begin
                if (idx < 8) begin
                    a = pa[idx];
                    b = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8 || idx != 8 || q.size() != 0 || bad != 0) begin
            errors++;
            $display("FAIL b2b_results got results=%0d accepts=%0d left=%0d bad=%0d want 8 8 0 0", got, idx, q.size(), bad);
        end
        iv = 0;
        for (int i = 1; i < idx; i++) if (acc_t[i] - acc_t[i-1] != 6) iv++;
        checks++;
        if (iv != 0) begin errors++; $display("FAIL b2b_spacing got %0d gaps not 6 want 0", iv); end
        tick();
    endtask

    task automatic test_stability();
        logic [15:0] x, y;
        bit ok;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            present(x, y, ok);
            wait_out(lat, ok);
            checks++;
            if (!ok || lat != 4 || prod !== model(x, y)) begin
                errors++;
                $display("FAIL stability_%0d got %h lat %0d want %h lat 4", i, prod, lat, model(x, y));
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
